cam_pattern_gen: RTL

- Synthesizable OV7670-style pixel-bus transmitter. Drives pixel clock, VSYNC, HREF and 8-bit data in RGB565, two bytes per pixel.
- Acts as the sending end for the capture block `cam_read`, so capture, buffer RAM and the VGA path can be brought up and regression-tested without a physical sensor.
- Sits in place of the camera pins, or in the bench in front of `cam_read`.

---
 rtl/cam_pattern_gen.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/cam_pattern_gen.sv
// OV7670-style pixel-bus transmitter: drives pclk/vsync/href and RGB565 bytes
// (high byte first) carrying one of four test patterns, frame after frame while en is high.
module cam_pattern_gen #(
    parameter int CAM_SCREEN_X = 160,
    parameter int CAM_SCREEN_Y = 120,
    parameter int H_BLANK      = 16,
    parameter int VSYNC_LINES  = 3,
    parameter int V_BACK       = 2,
    parameter int V_FRONT      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  mode,
    input  logic [15:0] solid_rgb,
    output logic        pclk,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  px_data,
    output logic        frame_done,
    output logic [7:0]  frame_cnt
);

    localparam int LINE_TP = 2 * CAM_SCREEN_X + H_BLANK;
    localparam int COL_W   = $clog2(LINE_TP);
    localparam int LINE_W  = $clog2(CAM_SCREEN_Y + VSYNC_LINES + V_BACK + V_FRONT + 1);
    localparam int BAR_W   = CAM_SCREEN_X / 8;

    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(LINE_TP - 1);
    localparam logic [COL_W-1:0]  ACT_COLS   = COL_W'(2 * CAM_SCREEN_X);
    localparam logic [LINE_W-1:0] VS_LAST    = LINE_W'(VSYNC_LINES - 1);
    localparam logic [LINE_W-1:0] VB_LAST    = LINE_W'(V_BACK - 1);
    localparam logic [LINE_W-1:0] ACT_LAST   = LINE_W'(CAM_SCREEN_Y - 1);
    localparam logic [LINE_W-1:0] VF_LAST    = LINE_W'(V_FRONT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } state_t;

    function automatic logic [15:0] bar_colour(input logic [15:0] bar);
        logic [15:0] c;
        case (bar)
            16'd0:   c = 16'hFFFF;
            16'd1:   c = 16'hFFE0;
            16'd2:   c = 16'h07FF;
            16'd3:   c = 16'h07E0;
            16'd4:   c = 16'hF81F;
            16'd5:   c = 16'hF800;
            16'd6:   c = 16'h001F;
            16'd7:   c = 16'h0000;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

    function automatic logic [15:0] pattern_pixel(input logic [1:0]  md,
                                                  input logic [15:0] x,
                                                  input logic [15:0] y,
                                                  input logic [15:0] rgb,
                                                  input logic [4:0]  b);
        logic [15:0] p;
        case (md)
            2'd0:    p = bar_colour(x / 16'(BAR_W));
            2'd1:    p = {x[4:0], y[5:0], b};
            2'd2:    p = rgb;
            2'd3:    p = y * 16'(CAM_SCREEN_X) + x;
            default: p = 16'h0000;
        endcase
        return p;
    endfunction

    state_t             state_r, state_s;
    logic [COL_W-1:0]   col_r, col_s;
    logic [LINE_W-1:0]  line_r, line_s;
    logic [1:0]         mode_r;
    logic [15:0]        rgb_r;
    logic [4:0]         bval_r;
    logic               line_end_s;
    logic               latch_s;
    logic               done_s;
    logic               href_s;
    logic               vsync_s;
    logic [15:0]        pix_s;
    logic [7:0]         byte_s;

    // Next position/state for the upcoming tick; outputs are derived from it so they register together.
    always_comb begin
        state_s    = state_r;
        line_s     = line_r;
        latch_s    = 1'b0;
        done_s     = 1'b0;
        line_end_s = (col_r == COL_LAST);
        if (line_end_s) begin
            col_s = {COL_W{1'b0}};
        end else begin
            col_s = col_r + COL_W'(1);
        end
        case (state_r)
            ST_IDLE: begin
                col_s  = {COL_W{1'b0}};
                line_s = {LINE_W{1'b0}};
                if (en) begin
                    state_s = ST_VSYNC;
                    latch_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_VSYNC: begin
                if (line_end_s && line_r == VS_LAST) begin
                    line_s  = {LINE_W{1'b0}};
                    state_s = ST_VBACK;
                end else if (line_end_s) begin
                    line_s = line_r + LINE_W'(1);
                end else begin
                    line_s = line_r;
                end
            end
            ST_VBACK: begin
                if (line_end_s && line_r == VB_LAST) begin
                    line_s  = {LINE_W{1'b0}};
                    state_s = ST_ACTIVE;
                end else if (line_end_s) begin
                    line_s = line_r + LINE_W'(1);
                end else begin
                    line_s = line_r;
                end
            end
            ST_ACTIVE: begin
                if (line_end_s && line_r == ACT_LAST) begin
                    line_s  = {LINE_W{1'b0}};
                    state_s = ST_VFRONT;
                end else if (line_end_s) begin
                    line_s = line_r + LINE_W'(1);
                end else begin
                    line_s = line_r;
                end
            end
            ST_VFRONT: begin
                if (line_end_s && line_r == VF_LAST) begin
                    line_s = {LINE_W{1'b0}};
                    done_s = 1'b1;
                    if (en) begin
                        state_s = ST_VSYNC;
                        latch_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else if (line_end_s) begin
                    line_s = line_r + LINE_W'(1);
                end else begin
                    line_s = line_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                col_s   = {COL_W{1'b0}};
                line_s  = {LINE_W{1'b0}};
            end
        endcase
    end

    // Pixel byte for the next column: even columns carry the high byte.
    always_comb begin
        pix_s   = pattern_pixel(mode_r, 16'(col_s >> 1), 16'(line_s), rgb_r, bval_r);
        vsync_s = (state_s == ST_VSYNC);
        href_s  = (state_s == ST_ACTIVE) && (col_s < ACT_COLS);
        if (!href_s) begin
            byte_s = 8'h00;
        end else if (col_s[0]) begin
            byte_s = pix_s[7:0];
        end else begin
            byte_s = pix_s[15:8];
        end
    end

    // Pixel clock divider and tick-qualified FSM/output registers; ticks are pclk falling edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pclk       <= 1'b0;
            state_r    <= ST_IDLE;
            col_r      <= {COL_W{1'b0}};
            line_r     <= {LINE_W{1'b0}};
            vsync      <= 1'b0;
            href       <= 1'b0;
            px_data    <= 8'h00;
            frame_done <= 1'b0;
            frame_cnt  <= 8'h00;
            mode_r     <= 2'd0;
            rgb_r      <= 16'h0000;
            bval_r     <= 5'd0;
        end else begin
            pclk       <= ~pclk;
            frame_done <= 1'b0;
            if (pclk) begin
                state_r <= state_s;
                col_r   <= col_s;
                line_r  <= line_s;
                vsync   <= vsync_s;
                href    <= href_s;
                px_data <= byte_s;
                if (latch_s) begin
                    mode_r <= mode;
                    rgb_r  <= solid_rgb;
                    // Gradient blue follows the count including the frame finishing on this tick.
                    bval_r <= done_s ? (frame_cnt[4:0] + 5'd1) : frame_cnt[4:0];
                end
                if (done_s) begin
                    frame_done <= 1'b1;
                    frame_cnt  <= frame_cnt + 8'd1;
                end
            end
        end
    end

endmodule
